// File: rtl/audio_rom_player.sv
// Playback sequencer for the on-chip 16-bit audio sample ROM.
// On an accepted start it walks the word range [start_addr..end_addr], fetching each sample
// from a synchronous ROM and presenting it on a valid/ready stream. It can optionally loop
// over the range.
//
// Ports:
//   clk, reset                  system clock; asynchronous active-high reset
//   start, stop, loop_en        control (stop has the highest priority)
//   start_addr, end_addr        inclusive word range, latched on an accepted start
//   rom_address, rom_chipselect,
//   rom_clken, rom_readdata     ROM read port (data valid one cycle after the address load)
//   sample_data, sample_valid,
//   sample_ready                output sample stream
//   busy, done, cfg_err         status (done is a pulse; cfg_err is sticky)
module audio_rom_player #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NUM_WORDS = 240256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_chipselect,
  output logic              rom_clken,
  input  logic [DATA_W-1:0] rom_readdata,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [ADDR_W-1:0] MaxAddr = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRead, StCapture, StOut} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;
  logic              range_ok;

  assign range_ok = (start_addr <= end_addr) && (end_addr <= MaxAddr);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    start_d    = start_q;
    end_d      = end_q;
    data_d     = data_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    cfg_err_d  = cfg_err_q;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          if (range_ok) begin
            start_d    = start_addr;
            end_d      = end_addr;
            cur_addr_d = start_addr;
            cfg_err_d  = 1'b0;
            state_d    = StRead;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StRead: begin
        state_d = StCapture;
      end
      StCapture: begin
        data_d  = rom_readdata;
        valid_d = 1'b1;
        state_d = StOut;
      end
      StOut: begin
        if (sample_ready) begin
          valid_d = 1'b0;
          if (cur_addr_q != end_q) begin
            cur_addr_d = cur_addr_q + ADDR_W'(1);
            state_d    = StRead;
          end else if (loop_en) begin
            // loop_en is sampled live at the end-of-range handshake
            cur_addr_d = start_q;
            state_d    = StRead;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a same-cycle handshake
    if (stop && (state_q != StIdle)) begin
      state_d = StIdle;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cur_addr_q <= '0;
      start_q    <= '0;
      end_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      start_q    <= start_d;
      end_q      <= end_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign rom_address    = cur_addr_q;
  assign rom_chipselect = (state_q == StRead);
  assign rom_clken      = (state_q == StRead);
  assign sample_data    = data_q;
  assign sample_valid   = valid_q;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign cfg_err        = cfg_err_q;

endmodule
